reg_file_sb: RTL
================

Name: reg_file_sb

Overview:
- Next-generation datapath register file: 2 combinational read ports, 1 clocked write port with separate write index.
- Adds write-to-read bypass, a per-register pending (scoreboard) bit for in-flight results, and a sequential clear engine that zeroes the array after reset or on request.
- Sits between decode (read/reserve) and writeback (write/release) in the Bananachine core.

Parameters:
- WIDTH, 16, data width of each register.
- REG_BITS, 4, index width; DEPTH = 2**REG_BITS registers.
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = no forwarding.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- reg_write  input  1  write enable.
- write_index  input  REG_BITS  register written.
- write_data  input  WIDTH  data written.
- A_index  input  REG_BITS  read port A select.
- B_index  input  REG_BITS  read port B select.
- A_data  output  WIDTH  read port A data.
- B_data  output  WIDTH  read port B data.
- reserve_en  input  1  set pending bit of reserve_index.
- reserve_index  input  REG_BITS  register being reserved by an issuing instruction.
- A_pending  output  1  A_index has an outstanding producer.
- B_pending  output  1  B_index has an outstanding producer.
- clear_req  input  1  request full-array zero sweep.
- busy  output  1  clear sweep in progress.
- clear_done  output  1  one-cycle pulse after a sweep completes.

Behaviour:
- Reset: async, active-high. Pending bits -> 0, sweep counter -> 0, FSM -> CLEAR, clear_done -> 0. Array is not reset directly; the sweep zeroes it.
- Outputs during reset: busy=1, A_data=B_data=0, A_pending=B_pending=0.
- FSM has two states, CLEAR and IDLE.
- CLEAR state:
  - Each cycle writes 0 to RAM[cnt]; cnt increments.
  - When cnt==DEPTH-1, the zero write completes and the FSM moves to IDLE.
  - The sweep takes exactly DEPTH cycles. cnt wraps to 0.
  - reg_write, reserve_en and clear_req are ignored.
  - Pending bits are held at 0.
  - busy=1; A_data, B_data, A_pending and B_pending are forced to 0.
- IDLE state:
  - busy=0.
  - clear_req=1 -> CLEAR next cycle; any write or reserve in that same cycle is dropped.
  - clear_done is registered: it is 1 for exactly the first IDLE cycle following a sweep.
- Reset mid-sweep restarts the sweep from cnt=0.
- Register 0:
  - Reads always return 0, with no bypass from index 0.
  - Writes to index 0 are discarded.
  - Its pending bit never sets.
- Write: if IDLE and reg_write=1 and write_index!=0, RAM[write_index] <= write_data at the rising edge. The same edge clears pending[write_index].
- Reserve: if IDLE and reserve_en=1 and reserve_index!=0, pending[reserve_index] <= 1.
- Write and reserve to the same index in the same cycle: reserve wins, so the bit ends at 1 (new producer issued).
- Read data (IDLE):
  - A_data = 0 if A_index==0.
  - Otherwise, if BYPASS and reg_write and write_index==A_index, A_data = write_data.
  - Otherwise A_data = RAM[A_index].
  - B port is identical.
  - Purely combinational, zero latency.
- Pending outputs (IDLE):
  - A_pending = pending[A_index], except forced to 0 when a BYPASS hit occurs on port A that cycle.
  - With BYPASS=0, a write to A_index in the current cycle does not mask pending; the bit is 1 until the edge.
  - B port is identical.
- Both read ports may select the same index; each sees identical data and pending.
- Widths: write_data is stored unmodified; no sign extension or truncation.

Test Plan:
- Reset then idle: assert reset 2 cycles, release -> busy=1 for exactly 16 cycles (REG_BITS=4), clear_done=1 on cycle 17 only; then read A_index=5 -> A_data=0x0000.
- Write/read and r0: write 0xBEEF to r3, next cycle A_index=3, B_index=3 -> both 0xBEEF; write 0x1234 to r0, A_index=0 -> 0x0000.
- Bypass: BYPASS=1, reg_write=1, write_index=7, write_data=0xA5A5, A_index=7 in the same cycle -> A_data=0xA5A5 before the edge. Repeat with BYPASS=0 -> old value 0x0000.
- Scoreboard:
  - reserve r4 -> A_index=4 gives A_pending=1.
  - Write r4=0x0042 -> pending cleared after the edge (and 0 during the write cycle with BYPASS=1).
  - Same-cycle reserve+write r4 -> A_pending stays 1.
- clear_req: fill r1..r15 with 0xFFFF, pulse clear_req -> busy 16 cycles; a reg_write and reserve issued mid-sweep are ignored; after clear_done all reads =0, all pending=0.
- Reset mid-sweep: assert reset at sweep cycle 8 -> sweep restarts, busy lasts 16 more cycles after release, single clear_done pulse.

Source files
------------

// File: rtl/reg_file_sb.sv
// reg_file_sb: datapath register file with write-to-read bypass, a per-register
// pending (scoreboard) bit and a sequential zeroing sweep.
//
// Ports
//   clk, reset                  clock, asynchronous active-high reset
//   reg_write/write_index/write_data    write port (writeback)
//   reserve_en/reserve_index    sets the pending bit of an issuing producer (decode)
//   A_index/B_index             read selects
//   A_data/B_data               combinational read data
//   A_pending/B_pending         selected register has an outstanding producer
//   clear_req                   request a full-array zero sweep
//   busy                        sweep in progress (reads/pending forced to 0)
//   clear_done                  one-cycle pulse in the first idle cycle after a sweep
//
// Register 0 reads as zero, ignores writes and never becomes pending.

// One read port: picks bypass data, array data or zero, and masks pending on a
// bypass hit since the producer's result is being delivered this cycle.
module reg_file_sb_rd_port #(
    parameter int WIDTH    = 16,
    parameter int REG_BITS = 4,
    parameter int BYPASS   = 1
) (
    input  logic                                 idle,
    input  logic [REG_BITS-1:0]                  rd_index,
    input  logic [(2**REG_BITS)-1:0][WIDTH-1:0]  ram,
    input  logic [(2**REG_BITS)-1:0]             pending,
    input  logic                                 reg_write,
    input  logic [REG_BITS-1:0]                  write_index,
    input  logic [WIDTH-1:0]                     write_data,
    output logic [WIDTH-1:0]                     rd_data,
    output logic                                 rd_pending
);
    logic zero_sel;
    logic hit;

    assign zero_sel = ~idle | (rd_index == '0);
    assign hit      = (BYPASS != 0) & reg_write & (write_index == rd_index);

    always_comb begin
        rd_data    = '0;
        rd_pending = 1'b0;
        if (!zero_sel) begin
            rd_data    = hit ? write_data : ram[rd_index];
            rd_pending = pending[rd_index] & ~hit;
        end
    end
endmodule

module reg_file_sb #(
    parameter int WIDTH    = 16,
    parameter int REG_BITS = 4,
    parameter int BYPASS   = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                reg_write,
    input  logic [REG_BITS-1:0] write_index,
    input  logic [WIDTH-1:0]    write_data,
    input  logic [REG_BITS-1:0] A_index,
    input  logic [REG_BITS-1:0] B_index,
    output logic [WIDTH-1:0]    A_data,
    output logic [WIDTH-1:0]    B_data,
    input  logic                reserve_en,
    input  logic [REG_BITS-1:0] reserve_index,
    output logic                A_pending,
    output logic                B_pending,
    input  logic                clear_req,
    output logic                busy,
    output logic                clear_done
);
    localparam int DEPTH     = 2**REG_BITS;
    localparam int NUM_PORTS = 2;

    typedef enum logic {CLEAR = 1'b0, IDLE = 1'b1} state_t;

    state_t                          state, state_nxt;
    logic [REG_BITS-1:0]             cnt;
    logic [DEPTH-1:0][WIDTH-1:0]     ram;
    logic [DEPTH-1:0]                pending;
    logic                            idle;
    logic                            ops_en;
    logic                            wr_en;
    logic                            rs_en;
    logic                            sweep_last;

    logic [NUM_PORTS-1:0][REG_BITS-1:0] rd_idx;
    logic [NUM_PORTS-1:0][WIDTH-1:0]    rd_data;
    logic [NUM_PORTS-1:0]               rd_pend;

    assign idle       = (state == IDLE);
    // A clear request in idle drops any write/reserve presented with it.
    assign ops_en     = idle & ~clear_req;
    assign wr_en      = ops_en & reg_write  & (write_index   != '0);
    assign rs_en      = ops_en & reserve_en & (reserve_index != '0);
    assign sweep_last = (cnt == REG_BITS'(DEPTH-1));

    // ---- FSM: state register ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= CLEAR;
        else       state <= state_nxt;
    end

    // ---- FSM: next state ----
    always_comb begin
        state_nxt = state;
        case (state)
            CLEAR:   if (sweep_last) state_nxt = IDLE;
            IDLE:    if (clear_req)  state_nxt = CLEAR;
            default: state_nxt = CLEAR;
        endcase
    end

    // ---- FSM: outputs ----
    always_comb begin
        busy = (state == CLEAR);
    end

    // Sweep counter advances only while clearing; it wraps to 0 on the last
    // step so the next sweep starts at register 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)              cnt <= '0;
        else if (state == CLEAR) cnt <= cnt + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) clear_done <= 1'b0;
        else       clear_done <= (state == CLEAR) & sweep_last;
    end

    // Array has no reset; the sweep is what establishes zeros.
    always_ff @(posedge clk) begin
        if (state == CLEAR)  ram[cnt]         <= '0;
        else if (wr_en)      ram[write_index] <= write_data;
    end

    // Reserve is applied after the write-clear so a same-cycle reserve wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= '0;
        end else if (!idle) begin
            pending <= '0;
        end else begin
            if (wr_en) pending[write_index]   <= 1'b0;
            if (rs_en) pending[reserve_index] <= 1'b1;
        end
    end

    // ---- read ports ----
    assign rd_idx = {B_index, A_index};

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_rd
        reg_file_sb_rd_port #(
            .WIDTH    (WIDTH),
            .REG_BITS (REG_BITS),
            .BYPASS   (BYPASS)
        ) u_rd (
            .idle        (idle),
            .rd_index    (rd_idx[p]),
            .ram         (ram),
            .pending     (pending),
            .reg_write   (reg_write),
            .write_index (write_index),
            .write_data  (write_data),
            .rd_data     (rd_data[p]),
            .rd_pending  (rd_pend[p])
        );
    end

    assign A_data    = rd_data[0];
    assign B_data    = rd_data[1];
    assign A_pending = rd_pend[0];
    assign B_pending = rd_pend[1];
endmodule
